// File: rtl/bitpacker_scheduler_if.sv
// Requester/bitpacker bundle for bitpacker_scheduler.
// Handshake: req_valid[i] offers a fragment; it is taken in a cycle where
// req_valid[i] && req_ready[i]. pk_valid has no ready (the bitpacker never stalls).
interface bitpacker_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_data;
    logic [6*NUM_REQ-1:0]  req_length;
    logic                  pk_valid;
    logic [31:0]           pk_data;
    logic [5:0]            pk_length;

    modport master (
        output req_valid, req_data, req_length,
        input  req_ready, pk_valid, pk_data, pk_length
    );

    modport slave (
        input  req_valid, req_data, req_length,
        output req_ready, pk_valid, pk_data, pk_length
    );
endinterface

// File: rtl/bitpacker_scheduler.sv
// Round-robin arbiter and frame sequencer feeding one bitpacker port; pads each frame to a word.
// Optional macro BITPACKER_SCHED_LENGTH_CLAMP_EN clamps lengths > 32 and flags length_error.
module bitpacker_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int WORD_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic                  frame_end,
    bitpacker_scheduler_if.slave  bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic [4:0]            bit_count,
    output logic [WORD_CNT_W-1:0] word_count,
    output logic                  length_error,
    output logic [1:0]            fsm_state
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             grant_any;
    logic [31:0]      sel_data;
    logic [5:0]       sel_len;
    logic [5:0]       acc_len;
    logic [5:0]       sum;
    logic [5:0]       fill_len;
    logic             pk_valid_q;
    logic [31:0]      pk_data_q;
    logic [5:0]       pk_length_q;

    function automatic logic [31:0] low_mask(input logic [5:0] len);
        if (len >= 6'd32) return '1;
        return (32'h1 << len[4:0]) - 32'h1;
    endfunction

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state == S_RUN && !frame_end) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!grant_any && bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        sel_data      = '0;
        sel_len       = '0;
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_data = bus.req_data[32*i +: 32];
                sel_len  = bus.req_length[6*i +: 6];
            end
            bus.req_ready[i] = grant_any && (grant_idx == IDX_W'(i));
        end
    end

`ifdef BITPACKER_SCHED_LENGTH_CLAMP_EN
    assign acc_len = (sel_len > 6'd32) ? 6'd32 : sel_len;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            length_error <= 1'b0;
        end else if (state == S_IDLE && start) begin
            length_error <= 1'b0;
        end else if (grant_any && sel_len > 6'd32) begin
            length_error <= 1'b1;
        end
    end
`else
    assign acc_len      = sel_len;
    assign length_error = 1'b0;
`endif

    assign sum      = {1'b0, bit_count} + acc_len;
    // Bits needed to reach the next word boundary; zero when already aligned.
    assign fill_len = {1'b0, 5'd0 - bit_count};

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= S_IDLE;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            pk_valid_q  <= 1'b0;
            pk_data_q   <= '0;
            pk_length_q <= '0;
            bit_count   <= '0;
            word_count  <= '0;
            frame_done  <= 1'b0;
        end else begin
            pk_valid_q <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        bit_count  <= '0;
                        word_count <= '0;
                    end
                end
                S_RUN: begin
                    if (frame_end) begin
                        state <= S_FLUSH;
                    end else if (grant_any) begin
                        rr_ptr      <= grant_idx;
                        pk_valid_q  <= 1'b1;
                        pk_data_q   <= sel_data & low_mask(acc_len);
                        pk_length_q <= acc_len;
                        bit_count   <= sum[4:0];
                        word_count  <= word_count + WORD_CNT_W'(sum[5]);
                    end
                end
                S_FLUSH: begin
                    state <= S_DONE;
                    if (fill_len != 6'd0) begin
                        pk_valid_q  <= 1'b1;
                        pk_data_q   <= low_mask(fill_len);
                        pk_length_q <= fill_len;
                        bit_count   <= '0;
                        word_count  <= word_count + WORD_CNT_W'(1);
                    end
                end
                default: begin
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pk_valid  = pk_valid_q;
    assign bus.pk_data   = pk_data_q;
    assign bus.pk_length = pk_length_q;
    assign busy          = (state == S_RUN) || (state == S_FLUSH);
    assign fsm_state     = state;
endmodule

// File: doc/bitpacker_scheduler.md
Name: bitpacker_scheduler

Overview:
- Round-robin arbiter and frame sequencer in front of the `bitpacker` in the entropy-coded output path.
- Shares one bitpacker input port between NUM_REQ Huffman code sources, e.g. the Y/Cb/Cr encoders.
- Tracks the packed bit position. At end of frame it inserts all-ones fill up to the next 32-bit word boundary, then reports completion.
- Issues at most one fragment per cycle. The bitpacker has no backpressure, so none is needed downstream.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
WORD_CNT_W, 16, width of emitted-word counter

Ports:
clock  input  1  system clock
nreset  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a frame (ignored unless IDLE)
frame_end  input  1  one-cycle pulse; ends the frame (ignored unless RUN)
req_valid  input  NUM_REQ  per-requester fragment valid
req_ready  output  NUM_REQ  per-requester accept, combinational
req_data  input  32*NUM_REQ  fragment bits, LSB-first; requester i at [32i+31:32i]
req_length  input  6*NUM_REQ  fragment length 0..32; requester i at [6i+5:6i]
pk_valid  output  1  to bitpacker data_in_valid, registered
pk_data  output  32  to bitpacker data_in, registered
pk_length  output  6  to bitpacker input_length, registered
busy  output  1  high in RUN or FLUSH
frame_done  output  1  one-cycle pulse after fill has been issued
bit_count  output  5  packed bits mod 32 since start
word_count  output  WORD_CNT_W  complete 32-bit words issued this frame
length_error  output  1  sticky; see Optional Feature

Behaviour:
- Reset (async, nreset low) values:
  - state=IDLE.
  - pk_valid=0, pk_data=0, pk_length=0.
  - bit_count=0, word_count=0.
  - frame_done=0, length_error=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-frame discards all state; no fill is emitted.
- States:
  - IDLE: start -> RUN; clears bit_count, word_count and length_error.
  - RUN: arbitrates. frame_end -> FLUSH. frame_end wins over arbitration: no grant in that cycle.
  - FLUSH: single cycle; issues fill, then -> DONE.
  - DONE: single cycle; frame_done=1, then -> IDLE.
- Arbitration (RUN only, not on a frame_end cycle):
  - Search from rr_ptr+1 with wrap; first i with req_valid[i] gets req_ready[i]=1. At most one ready per cycle.
  - On a grant, rr_ptr <= i.
  - req_ready is 0 in every state other than RUN.
- Accepted fragment, registered 1-cycle latency, appears on the next cycle:
  - pk_valid=1, pk_length=L.
  - pk_data = req_data masked to its low L bits; upper bits 0.
  - L=0 is accepted and forwarded with pk_length=0.
- Any cycle without an accept or fill: pk_valid=0; pk_data and pk_length hold their old values.
- Counters:
  - sum = bit_count + L, 6-bit.
  - bit_count <= sum[4:0].
  - word_count += sum[5], wrapping at 2^WORD_CNT_W.
- FLUSH fill:
  - F = (32 - bit_count) mod 32.
  - If F!=0: next cycle pk_valid=1, pk_length=F, pk_data = low F bits set to 1. word_count increments and bit_count becomes 0.
  - If F==0: no pk_valid.
- frame_done is asserted in DONE, one cycle after the fill beat, so the bitpacker has received the final word before completion is reported.
- start while not IDLE and frame_end while not RUN are ignored.

Optional Feature:
- Macro `BITPACKER_SCHED_LENGTH_CLAMP_EN`.
- Defined:
  - Accepted req_length > 32 is clamped to 32 (data masked to 32 bits).
  - length_error sets and stays set until the next start or reset.
- Undefined:
  - length_error tied 0; no clamp logic.
  - Lengths > 32 are forwarded unchanged. Counters still use the 6-bit sum, and behaviour downstream is undefined.

Test Plan:
- Reset, start, req_valid=3'b111 held with lengths 8 for 12 cycles -> grants in order 0,1,2,0,1,2,...; each pk beat 1 cycle after its accept; word_count=3, bit_count=0.
- Requester 1 only: data 32'hFFFF_FFFF, length 5 -> pk_data=32'h0000_001F, pk_length=5, bit_count=5.
- After total 37 bits, frame_end -> FLUSH beat pk_length=27, pk_data=32'h07FF_FFFF; frame_done pulses the next cycle; word_count=2, bit_count=0.
- After exactly 64 bits, frame_end -> no fill beat; frame_done pulses; word_count=2.
- frame_end in the same cycle as req_valid=3'b001 -> req_ready=0; start pulse during RUN ignored; nreset low mid-RUN -> all outputs at reset values immediately.
- With `BITPACKER_SCHED_LENGTH_CLAMP_EN` defined, length 40 -> pk_length=32, length_error=1 until the next start.
